// File: rtl/register_writeback_stage.sv
// rtl/register_writeback_stage.sv - in-order writeback buffer feeding the x86 register file write port
module register_writeback_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wr_en,
  input  logic [2:0]       in_dest_idx,
  input  logic [1:0]       in_size,
  input  logic [31:0]      in_result,
  input  logic             hold,
  output logic [2:0]       rf_ridx,
  input  logic [31:0]      rf_rdata,
  output logic             we,
  output logic [2:0]       widx,
  output logic [31:0]      wdata,
  output logic [7:0]       pending_mask,
  output logic [CNT_W-1:0] wb_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [2:0]       p_q    [DEPTH];
  logic             hi_q   [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [31:0]      res_q  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty, full, push, pop, in_hi;
  logic [2:0]       in_p, slot_p;
  logic [PTR_W-1:0] slot_off;
  logic [31:0]      old, res;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && in_wr_en;
  assign we       = !empty && !hold;
  assign pop      = we;

  // AH/CH/DH/BH live in bits 15:8 of EAX/ECX/EDX/EBX
  assign in_hi = (in_size == SZ_BYTE) && in_dest_idx[2];
  assign in_p  = in_hi ? {1'b0, in_dest_idx[1:0]} : in_dest_idx;

  assign rf_ridx      = p_q[head_q];
  assign widx         = p_q[head_q];
  assign pending_mask = mask_q;
  assign wb_count     = cnt_q;

  always_comb begin
    old = rf_rdata;
    res = res_q[head_q];
    wdata = res;
    if (size_q[head_q] == SZ_BYTE) begin
      wdata = hi_q[head_q] ? {old[31:16], res[7:0], old[7:0]} : {old[31:8], res[7:0]};
    end else if (size_q[head_q] == SZ_WORD) begin
      wdata = {old[31:16], res[15:0]};
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + PTR_ONE : head_q;
    tail_d  = push ? tail_q + PTR_ONE : tail_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    cnt_d = pop ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Mask is rebuilt from the post-edge FIFO contents so duplicates keep their bit
  always_comb begin
    mask_d   = '0;
    slot_off = '0;
    slot_p   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - head_d;
      slot_p   = (push && tail_q == PTR_W'(i)) ? in_p : p_q[i];
      if ({1'b0, slot_off} < count_d) begin
        mask_d[slot_p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      p_q[tail_q]    <= in_p;
      hi_q[tail_q]   <= in_hi;
      size_q[tail_q] <= in_size;
      res_q[tail_q]  <= in_result;
    end
  end

endmodule

// File: tb/tb_register_writeback_stage.sv
// tb/tb_register_writeback_stage.sv - randomized and directed bench for register_writeback_stage
module tb_register_writeback_stage;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_wr_en, hold, we;
  logic [2:0] in_dest_idx, rf_ridx, widx;
  logic [1:0] in_size;
  logic [31:0] in_result, rf_rdata, wdata;
  logic [7:0] pending_mask;
  logic [CNT_W-1:0] wb_count;

  register_writeback_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wr_en(in_wr_en), .in_dest_idx(in_dest_idx), .in_size(in_size),
    .in_result(in_result), .hold(hold), .rf_ridx(rf_ridx), .rf_rdata(rf_rdata),
    .we(we), .widx(widx), .wdata(wdata), .pending_mask(pending_mask),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT, written only through its write port
  logic [31:0] rf [8];
  assign rf_rdata = rf[rf_ridx];
  always @(posedge clk) if (we) rf[widx] <= wdata;

  typedef struct {
    logic [2:0]  p;
    bit          hi;
    logic [1:0]  sz;
    logic [31:0] r;
  } ent_t;

  ent_t q[$];
  bit [31:0] gold [8];
  logic [CNT_W-1:0] m_cnt;
  logic [34:0] log_q[$];
  int dut_writes = 0;
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [2:0] idx, input logic [1:0] sz, input logic [31:0] r);
    ent_t e;
    e.hi = (sz == 2'b00) && (idx >= 3'd4);
    e.p  = e.hi ? idx - 3'd4 : idx;
    e.sz = sz;
    e.r  = r;
    return e;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input ent_t e);
    if (e.sz == 2'b00 && e.hi) return (old & 32'hFFFF_00FF) | ((e.r & 32'hFF) << 8);
    if (e.sz == 2'b00)         return (old & 32'hFFFF_FF00) | (e.r & 32'hFF);
    if (e.sz == 2'b10)         return (old & 32'hFFFF_0000) | (e.r & 32'hFFFF);
    return e.r;
  endfunction

  function automatic logic [7:0] model_mask();
    logic [7:0] m = 8'h00;
    foreach (q[i]) m = m | (8'h01 << q[i].p);
    return m;
  endfunction

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = '0;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_we", we, 1'b0);
      check("rst_pending", pending_mask, 8'h00);
      check("rst_wb_count", wb_count, 0);
    end else begin
      check("in_ready", in_ready, q.size() < DEPTH);
      check("we", we, (q.size() > 0) && !hold);
      if (q.size() > 0 && !hold) begin
        check("widx", widx, q[0].p);
        check("rf_ridx", rf_ridx, q[0].p);
        check("wdata", wdata, merge(gold[q[0].p], q[0]));
      end
      check("pending_mask", pending_mask, model_mask());
      check("wb_count", wb_count, m_cnt);
      if (we) begin
        dut_writes++;
        log_q.push_back({widx, wdata});
        if (log_q.size() > 16) void'(log_q.pop_front());
      end
    end
  end

  // Model state advance at each active edge
  always @(posedge clk) begin
    if (!rst) begin
      bit do_pop, do_push;
      ent_t e;
      do_pop  = (q.size() > 0) && !hold;
      do_push = in_valid && (q.size() < DEPTH) && in_wr_en;
      if (do_pop) begin
        e = q.pop_front();
        gold[e.p] = merge(gold[e.p], e);
        m_cnt = m_cnt + 1'b1;
      end
      if (do_push) q.push_back(mk(in_dest_idx, in_size, in_result));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit en, input logic [2:0] idx, input logic [1:0] sz, input logic [31:0] r);
    bit ok = 0;
    in_valid = 1'b1; in_wr_en = en; in_dest_idx = idx; in_size = sz; in_result = r;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (pending_mask != 8'h00 && k < 100) begin
      cyc();
      k++;
    end
    if (k >= 100) check("idle_timeout", 0, 1);
  endtask

  function automatic logic [34:0] log_back(input int n);
    return log_q[log_q.size() - 1 - n];
  endfunction

  initial begin
    int wr_before;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_wr_en = 1'b0; in_dest_idx = '0;
    in_size = '0; in_result = '0; hold = 1'b0;
    repeat (2) cyc();
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_we", we, 1'b0);
    check("idle_pending", pending_mask, 8'h00);
    check("idle_wb_count", wb_count, 0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 8; i++) push(1'b1, 3'(i), 2'b11, 32'h0101_0101 * (i + 1));
    wait_idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    push(1'b1, 3'd0, 2'b11, 32'hAAAA_AAAA);
    check("seq_mask_01", pending_mask, 8'h01);
    push(1'b1, 3'd1, 2'b11, 32'hBBBB_BBBB);
    check("seq_mask_02", pending_mask, 8'h02);
    check("seq_write_eax", log_back(0), {3'd0, 32'hAAAA_AAAA});
    cyc();
    check("seq_mask_00", pending_mask, 8'h00);
    check("seq_wb_count", wb_count, 16'd2);
    check("seq_write_ecx", log_back(0), {3'd1, 32'hBBBB_BBBB});

    push(1'b1, 3'd2, 2'b11, 32'h1122_3344);
    push(1'b1, 3'd6, 2'b00, 32'h0000_00EE);
    push(1'b1, 3'd2, 2'b00, 32'h0000_0099);
    wait_idle();
    check("merge_dh", log_back(1), {3'd2, 32'h1122_EE44});
    check("merge_dl", log_back(0), {3'd2, 32'h1122_EE99});

    push(1'b1, 3'd3, 2'b11, 32'hDEAD_BEEF);
    push(1'b1, 3'd3, 2'b10, 32'hFFFF_5678);
    wait_idle();
    check("merge_word", log_back(0), {3'd3, 32'hDEAD_5678});

    hold = 1'b1;
    push(1'b1, 3'd5, 2'b11, 32'h5555_0001);
    push(1'b1, 3'd6, 2'b11, 32'h5555_0002);
    in_valid = 1'b1; in_wr_en = 1'b1; in_dest_idx = 3'd7; in_size = 2'b11; in_result = 32'h5555_0003;
    @(negedge clk);
    check("hold_full_ready", in_ready, 1'b0);
    cyc();
    @(negedge clk);
    check("hold_full_ready2", in_ready, 1'b0);
    check("hold_full_we", we, 1'b0);
    hold = 1'b0;
    cyc();
    check("hold_release_ready", in_ready, 1'b1);
    push(1'b1, 3'd7, 2'b11, 32'h5555_0003);
    wait_idle();
    check("hold_order0", log_back(2), {3'd5, 32'h5555_0001});
    check("hold_order1", log_back(1), {3'd6, 32'h5555_0002});
    check("hold_order2", log_back(0), {3'd7, 32'h5555_0003});
    check("hold_wb_count", wb_count, 16'd10);

    push(1'b0, 3'd4, 2'b11, 32'h1234_5678);
    repeat (3) cyc();
    check("drop_wb_count", wb_count, 16'd10);
    check("drop_pending", pending_mask, 8'h00);

    hold = 1'b1;
    push(1'b1, 3'd0, 2'b11, 32'h0BAD_0000);
    push(1'b1, 3'd1, 2'b11, 32'h0BAD_0001);
    check("midrst_pending_before", pending_mask, 8'h03);
    rst = 1'b1;
    #1;
    check("midrst_pending", pending_mask, 8'h00);
    check("midrst_we", we, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    hold = 1'b0;
    cyc();
    rst = 1'b0;
    wr_before = dut_writes;
    repeat (4) cyc();
    check("midrst_no_write", dut_writes, wr_before);
    check("midrst_wb_count", wb_count, 16'd0);
    check("midrst_eax_kept", rf[0], 32'hAAAA_AAAA);

    for (int c = 0; c < 3000; c++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_wr_en    = ($urandom_range(0, 7) != 0);
      in_dest_idx = 3'($urandom);
      in_size     = 2'($urandom);
      in_result   = $urandom;
      hold        = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      cyc();
    end
    in_valid = 1'b0; hold = 1'b0; rst = 1'b0;
    cyc();
    wait_idle();

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b1;
    in_wr_en = 1'b1;
    n = 0;
    for (int k = 0; k < 70000 && n < 65536; k++) begin
      in_dest_idx = 3'($urandom);
      in_size     = 2'($urandom);
      in_result   = $urandom;
      @(negedge clk);
      if (in_ready) n++;
      cyc();
    end
    in_valid = 1'b0;
    wait_idle();
    check("wrap_wb_count", wb_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
